lc3b_control: RTL and testbench

- Multi-cycle control FSM that sits directly upstream of the LC-3b datapath.
- Consumes the datapath's IR, condition codes (N, P, Z) and memory-ready (R).
- Drives every datapath load/enable strobe and the ALU opcode.
- Also provides a retired-instruction counter, a halt output and a memory-timeout error.

---
 rtl/lc3b_control.sv | 143 ++++++++++++++
 tb/tb_lc3b_control.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/lc3b_control.sv
// Multi-cycle Moore control FSM for the LC-3b datapath.
// It also tracks retired instructions, a halt state and memory-wait timeouts.
module lc3b_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      IR,
   input  logic             N,
   input  logic             Z,
   input  logic             P,
   input  logic             R,
   output logic [2:0]       aluop,
   output logic             LDCC,
   output logic             LDIR,
   output logic             LDREG,
   output logic             LDPC,
   output logic             LDMAR,
   output logic             LDMDR,
   output logic             MEMEN,
   output logic             br_taken,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] retired
);

   localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

   typedef enum logic [3:0] {
      S_RST, S_F_MAR, S_F_WAIT, S_F_MDR, S_F_IR, S_DECODE, S_EX_ALU, S_LD_MAR,
      S_LD_WAIT, S_LD_MDR, S_LD_REG, S_ST_MAR, S_ST_WR, S_EX_BR, S_NOP, S_HALT
   } state_t;

   state_t             state_q, state_d;
   logic [WCW-1:0]     wcnt_q, wcnt_d;
   logic [CNT_W-1:0]   ret_q, ret_d;
   logic [2:0]         alu_q, alu_d;
   logic               br_q, br_d;
   logic               err_q, err_d;
   logic               in_wait, last_wait, timeout, retire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RST;
         wcnt_q  <= '0;
         ret_q   <= '0;
         alu_q   <= 3'b000;
         br_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         ret_q   <= ret_d;
         alu_q   <= alu_d;
         br_q    <= br_d;
         err_q   <= err_d;
      end
   end

   assign in_wait   = (state_q == S_F_WAIT) || (state_q == S_LD_WAIT) || (state_q == S_ST_WR);
   assign last_wait = (wcnt_q == WCW'(MEM_TIMEOUT - 1));

   // ALU op and branch outcome are latched in DECODE so every output stays a pure function of state.
   always_comb begin
      state_d = state_q;
      alu_d   = alu_q;
      br_d    = br_q;
      timeout = 1'b0;
      case (state_q)
         S_RST:     state_d = S_F_MAR;
         S_F_MAR:   state_d = S_F_WAIT;
         S_F_WAIT:  if (R) state_d = S_F_MDR;
                    else if (last_wait) timeout = 1'b1;
         S_F_MDR:   state_d = S_F_IR;
         S_F_IR:    state_d = S_DECODE;
         S_DECODE: begin
            br_d = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
            case (IR[15:12])
               4'b0001: begin state_d = S_EX_ALU; alu_d = 3'b000; end
               4'b0101: begin state_d = S_EX_ALU; alu_d = 3'b001; end
               4'b1001: begin state_d = S_EX_ALU; alu_d = 3'b010; end
               4'b0110: state_d = S_LD_MAR;
               4'b0111: state_d = S_ST_MAR;
               4'b0000: state_d = S_EX_BR;
               4'b1111: state_d = (IR[7:0] == 8'h25) ? S_HALT : S_NOP;
               default: state_d = S_NOP;
            endcase
         end
         S_EX_ALU:  state_d = S_F_MAR;
         S_LD_MAR:  state_d = S_LD_WAIT;
         S_LD_WAIT: if (R) state_d = S_LD_MDR;
                    else if (last_wait) timeout = 1'b1;
         S_LD_MDR:  state_d = S_LD_REG;
         S_LD_REG:  state_d = S_F_MAR;
         S_ST_MAR:  state_d = S_ST_WR;
         S_ST_WR:   if (R) state_d = S_F_MAR;
                    else if (last_wait) timeout = 1'b1;
         S_EX_BR:   state_d = S_F_MAR;
         S_NOP:     state_d = S_F_MAR;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_RST;
      endcase
      if (timeout) state_d = S_HALT;
   end

   // Counter restarts on every entry into a wait state because any exit from one clears it.
   assign wcnt_d = (in_wait && state_d == state_q) ? wcnt_q + WCW'(1) : '0;
   assign err_d  = err_q | timeout;
   assign retire = (state_d == S_F_MAR) && (state_q != S_RST);
   assign ret_d  = retire ? ret_q + CNT_W'(1) : ret_q;

   always_comb begin
      aluop    = 3'b000;
      LDCC     = 1'b0;
      LDIR     = 1'b0;
      LDREG    = 1'b0;
      LDPC     = 1'b0;
      LDMAR    = 1'b0;
      LDMDR    = 1'b0;
      MEMEN    = 1'b0;
      br_taken = 1'b0;
      halted   = 1'b0;
      case (state_q)
         S_F_MAR:  begin LDMAR = 1'b1; LDPC = 1'b1; end
         S_F_MDR:  LDMDR = 1'b1;
         S_F_IR:   LDIR  = 1'b1;
         S_EX_ALU: begin LDREG = 1'b1; LDCC = 1'b1; aluop = alu_q; end
         S_LD_MAR: LDMAR = 1'b1;
         S_LD_MDR: LDMDR = 1'b1;
         S_LD_REG: begin LDREG = 1'b1; LDCC = 1'b1; aluop = 3'b011; end
         S_ST_MAR: LDMAR = 1'b1;
         S_ST_WR:  MEMEN = 1'b1;
         S_EX_BR:  br_taken = br_q;
         S_HALT:   halted = 1'b1;
         default:  ;
      endcase
   end

   assign mem_err = err_q;
   assign retired = ret_q;

endmodule

// File: tb/tb_lc3b_control.sv
// Directed bench for lc3b_control: default instance for the instruction flows,
// a short-timeout, 2-bit-counter instance for timeout and wrap boundaries.
module tb_lc3b_control;

   logic        clk = 1'b0;
   logic        rst1, rst2;
   logic [15:0] IR;
   logic        N, Z, P, R;
   logic        sel;
   int          total = 0;
   int          bad   = 0;

   logic [2:0]  aluop1, aluop2;
   logic        ldcc1, ldir1, ldreg1, ldpc1, ldmar1, ldmdr1, memen1, br1, halt1, err1;
   logic        ldcc2, ldir2, ldreg2, ldpc2, ldmar2, ldmdr2, memen2, br2, halt2, err2;
   logic [15:0] ret1;
   logic [1:0]  ret2;

   // {LDMAR,LDPC,LDMDR,LDIR,LDREG,LDCC,MEMEN,br_taken,halted,mem_err,aluop}
   localparam logic [12:0] E_NONE  = 13'b0000000000_000;
   localparam logic [12:0] E_FMAR  = 13'b1100000000_000;
   localparam logic [12:0] E_MDR   = 13'b0010000000_000;
   localparam logic [12:0] E_IR    = 13'b0001000000_000;
   localparam logic [12:0] E_ALU   = 13'b0000110000_000;
   localparam logic [12:0] E_MAR   = 13'b1000000000_000;
   localparam logic [12:0] E_LDREG = 13'b0000110000_011;
   localparam logic [12:0] E_MEMEN = 13'b0000001000_000;
   localparam logic [12:0] E_BR    = 13'b0000000100_000;
   localparam logic [12:0] E_HALT  = 13'b0000000010_000;
   localparam logic [12:0] E_HERR  = 13'b0000000011_000;

   logic [12:0] s1, s2, strb;
   logic [15:0] ret;
   assign s1   = {ldmar1, ldpc1, ldmdr1, ldir1, ldreg1, ldcc1, memen1, br1, halt1, err1, aluop1};
   assign s2   = {ldmar2, ldpc2, ldmdr2, ldir2, ldreg2, ldcc2, memen2, br2, halt2, err2, aluop2};
   assign strb = sel ? s2 : s1;
   assign ret  = sel ? {14'b0, ret2} : ret1;

   lc3b_control u1 (
      .clk(clk), .reset(rst1), .IR(IR), .N(N), .Z(Z), .P(P), .R(R),
      .aluop(aluop1), .LDCC(ldcc1), .LDIR(ldir1), .LDREG(ldreg1), .LDPC(ldpc1),
      .LDMAR(ldmar1), .LDMDR(ldmdr1), .MEMEN(memen1), .br_taken(br1),
      .halted(halt1), .mem_err(err1), .retired(ret1)
   );

   lc3b_control #(.MEM_TIMEOUT(4), .CNT_W(2)) u2 (
      .clk(clk), .reset(rst2), .IR(IR), .N(N), .Z(Z), .P(P), .R(R),
      .aluop(aluop2), .LDCC(ldcc2), .LDIR(ldir2), .LDREG(ldreg2), .LDPC(ldpc2),
      .LDMAR(ldmar2), .LDMDR(ldmdr2), .MEMEN(memen2), .br_taken(br2),
      .halted(halt2), .mem_err(err2), .retired(ret2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input string tag, input logic [12:0] e);
      step();
      chk(tag, {19'b0, strb}, {19'b0, e});
   endtask

   // Fetch through DECODE; R stays low for nlow wait cycles, then rises.
   task automatic fetch(input logic [15:0] ir, input int ret_e, input int nlow);
      step();
      chk("fmar", {19'b0, strb}, {19'b0, E_FMAR});
      chk("ret", {16'b0, ret}, 32'(ret_e));
      IR = ir;
      for (int k = 0; k <= nlow; k++) begin
         step();
         chk("fwait", {19'b0, strb}, {19'b0, E_NONE});
         R = (k == nlow);
      end
      cyc("fmdr", E_MDR);
      cyc("fir", E_IR);
      cyc("dec", E_NONE);
   endtask

   initial begin
      sel = 1'b0; rst1 = 1'b1; rst2 = 1'b1;
      IR = 16'h0000; N = 1'b0; Z = 1'b0; P = 1'b0; R = 1'b0;
      step(); step();
      chk("rst_strb", {19'b0, strb}, 32'd0);
      chk("rst_ret", {16'b0, ret}, 32'd0);
      rst1 = 1'b0;

      fetch(16'h1242, 0, 0);  cyc("add", E_ALU | 13'd0);
      fetch(16'h5242, 1, 0);  cyc("and", E_ALU | 13'd1);
      fetch(16'h927F, 2, 0);  cyc("not", E_ALU | 13'd2);

      N = 1'b1;
      fetch(16'h0A00, 3, 0);  cyc("br_n", E_BR);
      N = 1'b0; Z = 1'b1;
      fetch(16'h0A00, 4, 0);  cyc("br_z", E_NONE);
      Z = 1'b0;

      fetch(16'h7000, 5, 0);  cyc("st_mar", E_MAR);
      for (int k = 0; k < 5; k++) begin
         cyc("st_wr", E_MEMEN);
         R = (k == 4);
      end

      fetch(16'hF020, 6, 0);  cyc("trap_nop", E_NONE);

      fetch(16'h6000, 7, 0);
      cyc("ld_mar", E_MAR);
      cyc("ld_wait", E_NONE);
      cyc("ld_mdr", E_MDR);
      cyc("ld_reg", E_LDREG);

      fetch(16'h6000, 8, 0);
      cyc("ld_mar2", E_MAR);
      R = 1'b0;
      cyc("ld_wait2", E_NONE);
      cyc("ld_wait3", E_NONE);
      #2 rst1 = 1'b1;
      #1;
      chk("async_strb", {19'b0, strb}, 32'd0);
      chk("async_ret", {16'b0, ret}, 32'd0);
      step();
      rst1 = 1'b0;
      R = 1'b1;

      fetch(16'hF025, 0, 0);
      for (int k = 0; k < 3; k++) cyc("halt", E_HALT);
      chk("halt_ret", {16'b0, ret}, 32'd0);
      #2 rst1 = 1'b1;
      #1 chk("halt_rst", {19'b0, strb}, 32'd0);

      // Short-timeout instance: counter wrap, R winning on the timeout cycle, then timeout.
      sel = 1'b1;
      step();
      rst2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         fetch(16'hF020, i % 4, 0);
         cyc("nop2", E_NONE);
      end
      fetch(16'hF020, 1, 3);
      cyc("nop_edge", E_NONE);
      step();
      chk("to_fmar", {19'b0, strb}, {19'b0, E_FMAR});
      chk("to_ret", {16'b0, ret}, 32'd2);
      R = 1'b0;
      for (int k = 0; k < 4; k++) cyc("to_wait", E_NONE);
      for (int k = 0; k < 3; k++) cyc("to_halt", E_HERR);
      chk("to_ret2", {16'b0, ret}, 32'd2);
      #2 rst2 = 1'b1;
      #1 chk("to_rst", {19'b0, strb}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
